// File: rtl/d2l_slave_rx.sv
// Multi-lane serial frame receiver: start / data beats / optional parity / stop,
// sampled on falling sclk, with a one-word holding register and error pulses.
module d2l_slave_rx #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [LANES-1:0]  in_line,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              abort,
  output logic              overrun
);

  localparam int unsigned BEATS = DATA_W / LANES;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  beat, beat_nxt;
  logic [DATA_W-1:0] sr, sr_nxt, rx_data_nxt;
  logic              rx_valid_nxt, busy_nxt;
  logic              frame_err_nxt, abort_nxt, overrun_nxt;
  logic              word_ok;
  logic [LANES-1:0]  lanes_rev;

  // Lane 0 is the most significant bit of each beat.
  always_comb begin
    lanes_rev = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      lanes_rev[LANES-1-j] = in_line[j];
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    sr_nxt        = sr;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = rx_valid;
    frame_err_nxt = 1'b0;
    abort_nxt     = 1'b0;
    overrun_nxt   = 1'b0;
    word_ok       = 1'b0;

    if (state == IDLE) begin
      if (!cs_n) state_nxt = START;
    end else if (cs_n) begin
      // Deselect mid-frame overrides every symbol check.
      abort_nxt = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        START: begin
          if (in_line == '0) begin
            state_nxt = DATA;
            beat_nxt  = '0;
          end else begin
            frame_err_nxt = 1'b1;
            state_nxt     = IDLE;
          end
        end
        DATA: begin
          sr_nxt = DATA_W'({sr, lanes_rev});
          if (beat == LAST_BEAT) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            beat_nxt = beat + CNT_W'(1);
          end
        end
        PARITY: begin
          if (in_line[0] != ^sr) begin
            frame_err_nxt = 1'b1;
            state_nxt     = IDLE;
          end else begin
            state_nxt = STOP;
          end
        end
        STOP: begin
          state_nxt = START;
          if (&in_line) word_ok = 1'b1;
          else          frame_err_nxt = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // Holding register: load if free or being drained on the same edge.
    if (word_ok) begin
      if (!rx_valid || rx_ready) begin
        rx_data_nxt  = sr;
        rx_valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid_nxt = 1'b0;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat      <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      abort     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      sr        <= sr_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      busy      <= busy_nxt;
      frame_err <= frame_err_nxt;
      abort     <= abort_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_d2l_slave_rx.sv
// Bench for d2l_slave_rx: frame-level reference model, directed and random frames,
// plus a 4-lane / 16-bit / no-parity instance.
module tb_d2l_slave_rx;

  logic        sclk, rst_n;
  logic        cs_n, rx_ready;
  logic [1:0]  in_line;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, frame_err, abort, overrun;

  logic        cs4, rdy4;
  logic [3:0]  in4;
  logic [15:0] data4;
  logic        valid4, busy4, ferr4, ab4, ov4;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the holding register
  logic       m_valid;
  logic [7:0] m_data;
  logic       in_start;

  d2l_slave_rx dut (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .in_line(in_line), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err),
    .abort(abort), .overrun(overrun)
  );

  d2l_slave_rx #(.LANES(4), .DATA_W(16), .PARITY_EN(0)) dut4 (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs4), .in_line(in4), .rx_ready(rdy4),
    .rx_data(data4), .rx_valid(valid4), .busy(busy4), .frame_err(ferr4),
    .abort(ab4), .overrun(ov4)
  );

  initial begin
    sclk = 1'b1;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge sclk);
    #1;
  endtask

  // One 8-bit frame. kind: 0 ok, 1 bad start, 2 bad parity, 3 bad stop, 4 abort before beat ab.
  task automatic frame(input logic [7:0] w, input int kind, input int ab, input logic rdy,
                       input logic from_idle, output logic now_start);
    logic [4:0] exp;
    logic done;
    int k;
    done = 1'b0;
    now_start = 1'b0;
    for (int ph = (from_idle ? 0 : 1); ph <= 7 && !done; ph++) begin
      exp = 5'b10000;
      cs_n = 1'b0;
      in_line = 2'($urandom);
      rx_ready = 1'b0;
      if (ph == 1) begin
        if (kind == 1) begin
          in_line = 2'($urandom_range(1, 3));
          exp = 5'b01000;
          done = 1'b1;
        end else begin
          in_line = 2'b00;
        end
      end else if (ph >= 2 && ph <= 5) begin
        k = ph - 2;
        if (kind == 4 && ab == k) begin
          cs_n = 1'b1;
          exp = 5'b00100;
          done = 1'b1;
        end else begin
          in_line = {w[6-2*k], w[7-2*k]};
        end
      end else if (ph == 6) begin
        in_line[0] = (kind == 2) ? ~(^w) : ^w;
        if (kind == 2) begin
          exp = 5'b01000;
          done = 1'b1;
        end
      end else if (ph == 7) begin
        rx_ready = rdy;
        now_start = 1'b1;
        if (kind == 3) begin
          in_line = 2'($urandom_range(0, 2));
          exp[3] = 1'b1;
          if (m_valid && rdy) m_valid = 1'b0;
        end else begin
          in_line = 2'b11;
          if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_data = w;
          end else begin
            exp[1] = 1'b1;
          end
        end
      end
      exp[0] = m_valid;
      tick();
      n_tests++;
      if ({busy, frame_err, abort, overrun, rx_valid} !== exp || rx_data !== m_data) begin
        n_fail++;
        $display("FAIL frame w=%h kind=%0d ph=%0d: busy/ferr/abort/ovr/valid=%b data=%h, expected %b %h",
                 w, kind, ph, {busy, frame_err, abort, overrun, rx_valid}, rx_data, exp, m_data);
      end
    end
    rx_ready = 1'b0;
  endtask

  // Deselect while waiting in START after a stop symbol.
  task automatic close_frame();
    cs_n = 1'b1;
    in_line = 2'($urandom);
    rx_ready = 1'b0;
    tick();
    n_tests++;
    if ({busy, frame_err, abort, overrun, rx_valid} !== {4'b0010, m_valid} || rx_data !== m_data) begin
      n_fail++;
      $display("FAIL close: flags=%b data=%h, expected %b %h",
               {busy, frame_err, abort, overrun, rx_valid}, rx_data, {4'b0010, m_valid}, m_data);
    end
  endtask

  // Consumer drains the holding register while idle.
  task automatic test_drain();
    cs_n = 1'b1;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_valid = 1'b0;
    n_tests++;
    if ({busy, frame_err, abort, overrun, rx_valid} !== 5'b0 || rx_data !== m_data) begin
      n_fail++;
      $display("FAIL drain: flags=%b data=%h, expected 00000 %h",
               {busy, frame_err, abort, overrun, rx_valid}, rx_data, m_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cs_n = 1'b1; in_line = '0; rx_ready = 1'b0;
    cs4 = 1'b1; in4 = '0; rdy4 = 1'b0;
    m_valid = 1'b0; m_data = '0; in_start = 1'b0;
    #3;
    n_tests++;
    if ({rx_data, rx_valid, busy, frame_err, abort, overrun} !== 13'b0 ||
        {data4, valid4, busy4, ferr4, ab4, ov4} !== 21'b0) begin
      n_fail++;
      $display("FAIL reset: dut=%h/%b dut4=%h/%b, expected all zero",
               rx_data, {rx_valid, busy, frame_err, abort, overrun}, data4, {valid4, busy4, ferr4, ab4, ov4});
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_parity_err();
    logic st;
    frame(8'hA5, 2, -1, 1'b0, 1'b1, st);
  endtask

  task automatic test_abort();
    logic st;
    cs_n = 1'b1;
    frame(8'hA5, 4, 2, 1'b0, 1'b1, st);
  endtask

  task automatic test_basic();
    logic st;
    frame(8'hA5, 0, -1, 1'b0, 1'b1, st);
    close_frame();
    n_tests++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_a5: data=%h valid=%b, expected a5 1", rx_data, rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic st;
    test_drain();
    frame(8'h3C, 0, -1, 1'b0, 1'b1, st);
    frame(8'hC3, 0, -1, 1'b0, 1'b0, st);
    close_frame();
    n_tests++;
    if (rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_overrun: data=%h, expected 3c", rx_data);
    end
    test_drain();
    frame(8'h3C, 0, -1, 1'b1, 1'b1, st);
    frame(8'hC3, 0, -1, 1'b1, 1'b0, st);
    close_frame();
    n_tests++;
    if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: data=%h valid=%b, expected c3 1", rx_data, rx_valid);
    end
  endtask

  task automatic test_mid_reset();
    logic st;
    cs_n = 1'b0; in_line = 2'b01;
    tick();
    in_line = 2'b00;
    tick();
    in_line = 2'b10;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data = '0;
    n_tests++;
    if ({rx_data, rx_valid, busy, frame_err, abort, overrun} !== 13'b0 ||
        {data4, valid4, busy4, ferr4, ab4, ov4} !== 21'b0) begin
      n_fail++;
      $display("FAIL mid_reset: dut=%h/%b dut4=%h/%b, expected all zero",
               rx_data, {rx_valid, busy, frame_err, abort, overrun}, data4, {valid4, busy4, ferr4, ab4, ov4});
    end
    tick();
    rst_n = 1'b1;
    frame(8'h5A, 0, -1, 1'b0, 1'b1, st);
    close_frame();
  endtask

  task automatic test_wide(input logic [15:0] w);
    cs4 = 1'b0;
    in4 = 4'($urandom);
    tick();
    in4 = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) in4[j] = w[15-4*k-j];
      tick();
    end
    in4 = 4'hF;
    rdy4 = 1'b1;
    tick();
    rdy4 = 1'b0;
    n_tests++;
    if (data4 !== w || valid4 !== 1'b1 || {busy4, ferr4, ab4, ov4} !== 4'b1000) begin
      n_fail++;
      $display("FAIL wide: data=%h valid=%b flags=%b, expected %h 1 1000",
               data4, valid4, {busy4, ferr4, ab4, ov4}, w);
    end
    cs4 = 1'b1;
    tick();
    n_tests++;
    if (data4 !== w || {busy4, ab4} !== 2'b01) begin
      n_fail++;
      $display("FAIL wide_close: data=%h busy/abort=%b, expected %h 01", data4, {busy4, ab4}, w);
    end
  endtask

  task automatic test_random();
    logic st;
    int r, kind, ab;
    in_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 6) ? 0 : r - 5;
      ab = int'($urandom_range(0, 3));
      frame(8'($urandom), kind, ab, 1'($urandom), !in_start, st);
      in_start = st;
      if (in_start && $urandom_range(0, 2) == 0) begin
        close_frame();
        in_start = 1'b0;
      end
      if (!in_start && $urandom_range(0, 1) == 1) test_drain();
    end
    if (in_start) close_frame();
  endtask

  initial begin
    test_reset();
    test_parity_err();
    test_abort();
    test_basic();
    test_drain();
    test_back_to_back();
    test_mid_reset();
    test_wide(16'hBEEF);
    test_wide(16'($urandom));
    test_wide(16'($urandom));
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
